spi_reg_file_ctrl: RTL and testbench
====================================

SPI_REG_FILE_CTRL -- requirements
Module: spi_reg_file_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 8-bit configuration registers (legal 2..128).
REQ-002 Parameter ADDR_W, default $clog2(NUM_REGS): pointer width.
REQ-003 Ports, clock and reset first:
- sclk  in  1  SPI clock; the only clock; all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- byte_in  in  8  completed byte from the serial-to-parallel stage.
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle.
- frame_end  in  1  level; high means the message has stopped; synchronous frame abort.
- reg_out  out  8*NUM_REGS  flat register file; reg k occupies bits [8k+7:8k].
- rd_data  out  8  readback byte for the output shifter.
- wr_strobe  out  1  one-cycle pulse per accepted write.
- wr_addr  out  ADDR_W  address of the current or last write.
- addr_err  out  1  sticky flag for an illegal start address in the current frame.

Function
REQ-004 The first byte_valid after reset or frame_end SHALL be a command byte: bit7=1 write, bit7=0 read; bits[6:0] = start address.
REQ-005 FSM states: IDLE, WRITE, READ, DROP; reset and frame_end state is IDLE.
REQ-006 IDLE + byte_valid:
- start address < NUM_REGS: load ptr = bits[ADDR_W-1:0]; go to WRITE or READ per bit7.
- otherwise: go to DROP and set addr_err.
REQ-007 WRITE + byte_valid: reg[ptr] <= byte_in; wr_strobe=1 and wr_addr=ptr in the following cycle (1-cycle latency); ptr advances.
REQ-008 READ: rd_data SHALL equal reg[ptr] registered, valid one cycle after entering READ and after each byte_valid; each byte_valid advances ptr; byte_in is ignored and no register changes.
REQ-009 DROP: all byte_valid ignored, no writes, rd_data=0, until frame_end.
REQ-010 ptr advance SHALL wrap from NUM_REGS-1 to 0 (modulo NUM_REGS, not modulo 2^ADDR_W).
REQ-011 frame_end high SHALL override byte_valid in the same cycle: byte discarded, state <= IDLE, ptr <= 0, addr_err <= 0, rd_data <= 0; reg contents retained.
REQ-012 byte_valid in consecutive cycles SHALL each be processed; there are no back-pressure or stall cycles.
REQ-013 wr_strobe SHALL be low in every cycle except the one following an accepted write.
REQ-014 reg_out SHALL be a direct registered view; a write becomes visible one cycle after its byte_valid.

Reset
REQ-015 rstn low SHALL asynchronously clear all registers to 0x00, ptr to 0, state to IDLE, and all outputs to 0.
REQ-016 Release of rstn SHALL take effect on the next posedge sclk; no byte is accepted in the release cycle if byte_valid is also high in that cycle.

Structure
REQ-017 Shared package psec5_spi_pkg SHALL hold the state enum (IDLE/WRITE/READ/DROP), CMD_WRITE_BIT=7, and CMD_ADDR_MSB=6.
REQ-018 One sub-module, reg_bank (an NUM_REGS x 8 array with write enable, write address, and a registered read port), SHALL be instantiated; FSM and pointer logic stay at the top level.

Verification
REQ-019 Write burst: cmd 0x82, data 0xAA,0xBB,0xCC -> reg2=0xAA, reg3=0xBB, reg4=0xCC; three wr_strobe pulses with wr_addr 2,3,4.
REQ-020 Wrap: NUM_REGS=16; cmd 0x8F, data 0x11,0x22 -> reg15=0x11, reg0=0x22.
REQ-021 Read: preload reg5=0x5A and reg6=0xA5; cmd 0x05, then two dummy bytes -> rd_data 0x5A then 0xA5; reg_out unchanged.
REQ-022 Illegal address: cmd 0x90 (addr 16), data 0x77 -> addr_err=1, no wr_strobe, reg_out unchanged; after frame_end, addr_err=0.
REQ-023 Collision: cmd 0x81, then data 0x33 with frame_end high in the same cycle -> reg1 unchanged, state IDLE; the next byte 0x83 is parsed as a command.
REQ-024 Reset mid-burst: cmd 0x80, data 0x44, rstn pulsed low mid-cycle -> all reg_out=0 immediately and state IDLE.

Source files
------------

// File: rtl/psec5_spi_pkg.sv
// Shared types and command-byte field positions for the SPI register-file controller.
package psec5_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DROP  = 2'd3
    } state_e;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_MSB  = 6;

endpackage

// File: rtl/spi_reg_file_ctrl_reg_bank.sv
// NUM_REGS x 8 configuration register array with one write port, a registered
// read port that returns zero when not enabled, and a flat view of all registers.
module reg_bank #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [7:0]            rdata_o,
    output logic [8*NUM_REGS-1:0] regs_o
);

    logic [7:0] mem_q [NUM_REGS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= re_i ? mem_q[raddr_i] : 8'h00;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[8*k +: 8] = mem_q[k];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_reg_file_ctrl.sv
// Byte-level SPI command parser: first byte of a frame selects read/write and a
// start address, following bytes stream into or out of the register bank.
module spi_reg_file_ctrl
    import psec5_spi_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  frame_end,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic [7:0]            rd_data,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  addr_err
);

    localparam logic [7:0]        NUM_REGS_W = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   ptr_inc;
    logic                addr_err_q, addr_err_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                bank_we;
    logic                bank_re;
    logic                start_legal;

    // Pointer wraps at NUM_REGS, which need not be a power of two.
    assign ptr_inc     = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
    assign start_legal = ({1'b0, byte_in[CMD_ADDR_MSB:0]} < NUM_REGS_W);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        addr_err_d  = addr_err_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        bank_we     = 1'b0;

        if (frame_end) begin
            state_d    = IDLE;
            ptr_d      = '0;
            addr_err_d = 1'b0;
        end else if (byte_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (start_legal) begin
                        ptr_d   = byte_in[ADDR_W-1:0];
                        state_d = byte_in[CMD_WRITE_BIT] ? WRITE : READ;
                    end else begin
                        state_d    = DROP;
                        addr_err_d = 1'b1;
                    end
                end
                WRITE: begin
                    bank_we     = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = ptr_q;
                    ptr_d       = ptr_inc;
                end
                READ: begin
                    ptr_d = ptr_inc;
                end
                DROP: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Readback tracks the pointer only while a read frame is active, else zero.
    assign bank_re = (state_d == READ);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            addr_err_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            addr_err_q  <= addr_err_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    reg_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_bank (
        .clk_i   (sclk),
        .rst_ni  (rstn),
        .we_i    (bank_we),
        .waddr_i (ptr_q),
        .wdata_i (byte_in),
        .re_i    (bank_re),
        .raddr_i (ptr_d),
        .rdata_o (rd_data),
        .regs_o  (reg_out)
    );

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_file_ctrl.sv
// Randomized and directed bench for spi_reg_file_ctrl against a frame-level reference model.
module tb_spi_reg_file_ctrl;

    localparam int N  = 16;
    localparam int AW = 4;

    logic           sclk = 1'b0;
    logic           rstn = 1'b0;
    logic [7:0]     byte_in = 8'h00;
    logic           byte_valid = 1'b0;
    logic           frame_end = 1'b0;
    logic [8*N-1:0] reg_out;
    logic [7:0]     rd_data;
    logic           wr_strobe;
    logic [AW-1:0]  wr_addr;
    logic           addr_err;

    always #5 sclk = ~sclk;

    spi_reg_file_ctrl #(.NUM_REGS(N)) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .frame_end  (frame_end),
        .reg_out    (reg_out),
        .rd_data    (rd_data),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .addr_err   (addr_err)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: a frame is a command byte followed by a byte stream.
    logic [7:0]    mem [N];
    bit            in_frame;
    bit            is_wr;
    bit            legal;
    int            start;
    int            cnt;
    logic [7:0]    e_rd;
    logic [AW-1:0] e_waddr;
    bit            e_strobe;
    bit            e_err;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_regs();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[8*k +: 8] = mem[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) mem[k] = 8'h00;
        in_frame = 0; is_wr = 0; legal = 0; start = 0; cnt = 0;
        e_rd = 8'h00; e_waddr = '0; e_strobe = 0; e_err = 0;
    endtask

    task automatic model_cycle(input bit bv, input logic [7:0] b, input bit fe);
        int idx;
        e_strobe = 0;
        if (fe) begin
            in_frame = 0;
            e_err    = 0;
        end else if (bv) begin
            if (!in_frame) begin
                in_frame = 1;
                start    = int'(b[6:0]);
                cnt      = 0;
                is_wr    = b[7];
                legal    = (start < N);
                e_err    = !legal;
            end else if (legal) begin
                idx = (start + cnt) % N;
                if (is_wr) begin
                    mem[idx] = b;
                    e_strobe = 1;
                    e_waddr  = idx[AW-1:0];
                end
                cnt++;
            end
        end
        if (in_frame && legal && !is_wr) e_rd = mem[(start + cnt) % N];
        else                             e_rd = 8'h00;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".regs"},   128'(reg_out),   model_regs());
        chk({tag, ".rd"},     128'(rd_data),   128'(e_rd));
        chk({tag, ".strobe"}, 128'(wr_strobe), 128'(e_strobe));
        chk({tag, ".waddr"},  128'(wr_addr),   128'(e_waddr));
        chk({tag, ".err"},    128'(addr_err),  128'(e_err));
    endtask

    task automatic step(input bit bv, input logic [7:0] b, input bit fe, input string tag);
        byte_valid = bv;
        byte_in    = b;
        frame_end  = fe;
        @(posedge sclk);
        #1;
        model_cycle(bv, b, fe);
        byte_valid = 1'b0;
        frame_end  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        check_all("reset");
        #2 rstn = 1'b1;
        @(posedge sclk);
        #1;
        check_all("post_reset");

        // Write burst
        step(1, 8'h82, 0, "wb_cmd");
        step(1, 8'hAA, 0, "wb_d0");
        chk("wb_strobe0", 128'(wr_strobe), 128'(1));
        chk("wb_addr0",   128'(wr_addr),   128'(2));
        step(1, 8'hBB, 0, "wb_d1");
        chk("wb_addr1",   128'(wr_addr),   128'(3));
        step(1, 8'hCC, 0, "wb_d2");
        chk("wb_addr2",   128'(wr_addr),   128'(4));
        step(0, 8'h00, 0, "wb_idle");
        chk("wb_strobe_low", 128'(wr_strobe), 128'(0));
        chk("wb_reg2", 128'(reg_out[23:16]), 128'(8'hAA));
        chk("wb_reg4", 128'(reg_out[39:32]), 128'(8'hCC));
        step(0, 8'h00, 1, "wb_end");

        // Wrap at the last register
        step(1, 8'h8F, 0, "wr_cmd");
        step(1, 8'h11, 0, "wr_d0");
        step(1, 8'h22, 0, "wr_d1");
        step(0, 8'h00, 1, "wr_end");
        chk("wrap_reg15", 128'(reg_out[127:120]), 128'(8'h11));
        chk("wrap_reg0",  128'(reg_out[7:0]),     128'(8'h22));

        // Read back two preloaded registers
        step(1, 8'h85, 0, "pl_cmd");
        step(1, 8'h5A, 0, "pl_d0");
        step(1, 8'hA5, 0, "pl_d1");
        step(0, 8'h00, 1, "pl_end");
        step(1, 8'h05, 0, "rd_cmd");
        chk("rd_first", 128'(rd_data), 128'(8'h5A));
        step(1, 8'hFF, 0, "rd_dummy0");
        chk("rd_second", 128'(rd_data), 128'(8'hA5));
        step(1, 8'hFF, 0, "rd_dummy1");
        step(0, 8'h00, 1, "rd_end");
        chk("rd_cleared", 128'(rd_data), 128'(0));

        // Illegal start address
        step(1, 8'h90, 0, "ia_cmd");
        chk("ia_err_set", 128'(addr_err), 128'(1));
        step(1, 8'h77, 0, "ia_d0");
        chk("ia_no_strobe", 128'(wr_strobe), 128'(0));
        step(0, 8'h00, 1, "ia_end");
        chk("ia_err_clr", 128'(addr_err), 128'(0));

        // frame_end colliding with a data byte
        step(1, 8'h81, 0, "co_cmd");
        step(1, 8'h33, 1, "co_hit");
        chk("co_reg1", 128'(reg_out[15:8]), 128'(8'h00));
        step(1, 8'h83, 0, "co_newcmd");
        step(1, 8'h9C, 0, "co_d0");
        chk("co_reg3", 128'(reg_out[31:24]), 128'(8'h9C));
        step(0, 8'h00, 1, "co_end");

        // Asynchronous reset in the middle of a burst
        step(1, 8'h80, 0, "rs_cmd");
        step(1, 8'h44, 0, "rs_d0");
        #3 rstn = 1'b0;
        #1;
        chk("rs_regs_zero", 128'(reg_out), 128'(0));
        model_reset();
        check_all("rs_async");
        #2 rstn = 1'b1;
        step(1, 8'h86, 0, "rs_newcmd");
        step(1, 8'h66, 0, "rs_d1");
        chk("rs_reg6", 128'(reg_out[55:48]), 128'(8'h66));
        step(0, 8'h00, 1, "rs_end");

        // Randomized frames
        for (int i = 0; i < 600; i++) begin
            int act;
            logic [7:0] b;
            act = int'($urandom_range(0, 11));
            if (!in_frame) b = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
            else           b = 8'($urandom);
            if (act == 0)       step(0, b, 1, "rnd_fe");
            else if (act == 1)  step(1, b, 1, "rnd_coll");
            else if (act <= 9)  step(1, b, 0, "rnd_byte");
            else                step(0, b, 0, "rnd_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
